// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one uart_tx among NREQ byte requesters, with optional per-requester lock.
// Grant is same-cycle combinational (req_ready), tx_start from the next edge; requesters stall while a byte is in flight.
module uart_tx_arbiter #(
  parameter int NREQ          = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*8-1:0]       req_data,
  input  logic [NREQ-1:0]         req_lock,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         req_done,
  output logic [NREQ-1:0]         req_err,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  input  logic                    tx_busy,
  input  logic                    tx_done,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    active
);

  localparam int OW = $clog2(NREQ);
  localparam int SW = OW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY} state_t;

  state_t        state, state_n;
  logic [OW-1:0] rr_ptr, rr_n;
  logic [OW-1:0] owner_n;
  logic          lock_held, lock_n;
  logic [7:0]    cnt, cnt_n;
  logic          start_n;
  logic [7:0]    data_n;

  logic [NREQ-1:0] own_oh;
  logic [NREQ-1:0] cand;
  logic            found;
  logic [OW-1:0]   win;
  logic [7:0]      win_data;
  logic [SW-1:0]   sum;
  logic [OW-1:0]   idx;
  logic [OW-1:0]   next_owner;

  // Candidate selection and rotating search starting at rr_ptr.
  always_comb begin
    own_oh        = '0;
    own_oh[owner] = 1'b1;
    cand          = (lock_held && req_lock[owner]) ? (req_valid & own_oh) : req_valid;
    found         = 1'b0;
    win           = '0;
    sum           = '0;
    idx           = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + SW'(k);
      if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
      idx = sum[OW-1:0];
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    win_data = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (OW'(j) == win) win_data = req_data[j*8 +: 8];
    end
    next_owner = (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
  end

  always_comb begin
    state_n   = state;
    rr_n      = rr_ptr;
    owner_n   = owner;
    lock_n    = lock_held;
    cnt_n     = cnt;
    start_n   = tx_start;
    data_n    = tx_data;
    req_ready = '0;
    req_done  = '0;
    req_err   = '0;
    case (state)
      S_IDLE: begin
        // A released lock falls back to normal arbitration in the same cycle.
        if (lock_held && !req_lock[owner]) lock_n = 1'b0;
        if (found) begin
          req_ready[win] = 1'b1;
          data_n         = win_data;
          owner_n        = win;
          start_n        = 1'b1;
          cnt_n          = '0;
          state_n        = S_START;
        end
      end
      S_START: begin
        if (tx_busy) begin
          start_n = 1'b0;
          state_n = S_BUSY;
        end else if (cnt == 8'(START_TIMEOUT - 1)) begin
          req_err[owner] = 1'b1;
          start_n        = 1'b0;
          lock_n         = 1'b0;
          rr_n           = next_owner;
          state_n        = S_IDLE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_BUSY: begin
        // Only tx_done ends the byte; an early busy drop is not trusted.
        if (tx_done) begin
          req_done[owner] = 1'b1;
          rr_n            = next_owner;
          lock_n          = req_lock[owner];
          state_n         = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      lock_held <= 1'b0;
      cnt       <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_n;
      owner     <= owner_n;
      lock_held <= lock_n;
      cnt       <= cnt_n;
      tx_start  <= start_n;
      tx_data   <= data_n;
    end
  end

  assign active = (state != S_IDLE);

endmodule
